// File: rtl/async_queue_wr_arb_pkg.sv
// Shared types and constants for the async queue write-port arbiter.
package async_queue_wr_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int STAT_WIDTH = 16;

endpackage

// File: rtl/async_queue_rr_pick.sv
// Combinational round-robin picker: first set request bit at or above ptr,
// wrapping explicitly at NUM_REQ-1 so non-power-of-2 sizes work.
module async_queue_rr_pick #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic                found,
  output logic [ID_WIDTH-1:0] idx
);

  always_comb begin
    int cand;
    // NOTE: every combinational output gets a default first so no path
    // through the block can leave it unassigned and infer a latch.
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = int'(ptr) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = ID_WIDTH'(cand);
      end
    end
  end

endmodule

// File: rtl/async_queue_wr_arbiter.sv
// Packet-granular round-robin arbiter for the write port of an async queue.
// Optional per-requester packet counters: define ASYNC_QUEUE_WR_ARB_STATS_EN.
module async_queue_wr_arbiter
  import async_queue_wr_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic                          grant_valid,
  output logic [ID_WIDTH-1:0]           grant_id
`ifdef ASYNC_QUEUE_WR_ARB_STATS_EN
  ,
  input  logic [ID_WIDTH-1:0]           stat_sel,
  output logic [STAT_WIDTH-1:0]         stat_cnt
`endif
);

  arb_state_e            state_q, state_d;
  logic [ID_WIDTH-1:0]   rr_ptr;
  logic                  pick_found;
  logic [ID_WIDTH-1:0]   pick_idx;
  logic                  pkt_done;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  async_queue_rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Write path is combinational so fifo_full stops a write in the same cycle.
  always_comb begin
    state_d      = state_q;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    req_ready    = '0;
    pkt_done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) state_d = LOCKED;
      end
      LOCKED: begin
        fifo_wr_data        = data_arr[grant_id];
        fifo_wr_en          = req_valid[grant_id] & ~fifo_full;
        req_ready[grant_id] = fifo_wr_en;
        pkt_done            = fifo_wr_en & req_last[grant_id];
        if (pkt_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state_q  <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && pick_found) grant_id <= pick_idx;
      if (pkt_done) begin
        if (grant_id == ID_WIDTH'(NUM_REQ - 1)) rr_ptr <= '0;
        else                                    rr_ptr <= grant_id + 1'b1;
      end
    end
  end

  assign grant_valid = (state_q == LOCKED);

`ifdef ASYNC_QUEUE_WR_ARB_STATS_EN
  logic [STAT_WIDTH-1:0] stat_q [NUM_REQ];

  // NOTE: the counter array is a handful of flops, not a RAM, so it takes the
  // async reset like any other register.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
    end else if (pkt_done && (stat_q[grant_id] != '1)) begin
      stat_q[grant_id] <= stat_q[grant_id] + 1'b1;
    end
  end

  assign stat_cnt = stat_q[stat_sel];
`endif

endmodule

// File: doc/async_queue_wr_arbiter.md
# async_queue_wr_arbiter

Shares the write port of one async queue among NUM_REQ producers in the write clock domain. It performs round-robin arbitration at packet granularity: once a requester is granted, it keeps the write port until its last beat is accepted. The block drives the queue's write enable and data, and applies backpressure from the queue's full flag to the granted producer. It sits between the producer blocks and the write side of the async queue.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters; must be at least 2.
- DATA_WIDTH, 8: payload width; equals the queue's data width.
- ID_WIDTH, $clog2(NUM_REQ): width of the grant index.

Ports:
- wr_clk  in  1  write-domain clock.
- wr_rst_n  in  1  reset, asynchronous, active-low; clock wr_clk.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_data  in  NUM_REQ*DATA_WIDTH  payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  in  NUM_REQ  final beat of a packet.
- req_ready  out  NUM_REQ  beat accepted this cycle; one-hot or zero.
- fifo_full  in  1  full flag from the queue.
- fifo_wr_en  out  1  queue write enable.
- fifo_wr_data  out  DATA_WIDTH  queue write data.
- grant_valid  out  1  a requester is currently locked.
- grant_id  out  ID_WIDTH  index of the locked requester.

## Operation
- The FSM has two states, IDLE and LOCKED.
- **IDLE:** if any req_valid is set, pick the first set bit searching from rr_ptr upward with wrap-around. Register that index into grant_id and move to LOCKED. No beat is accepted in IDLE.
- **LOCKED:** with g = grant_id:
  - fifo_wr_en = req_valid[g] & ~fifo_full.
  - req_ready[g] = fifo_wr_en; all other req_ready bits are 0.
  - fifo_wr_data = req_data slice g. It is driven even when fifo_wr_en = 0.
- An accepted beat with req_last[g] = 1 sends the FSM to IDLE and sets rr_ptr = (g+1) mod NUM_REQ. The wrap happens explicitly at NUM_REQ-1, so it also holds for non-power-of-2 NUM_REQ.
- If req_valid[g] drops mid-packet, the grant is held. There is no timeout or pre-emption.
- While fifo_full is 1, nothing is accepted and the grant is held. The arbiter never asserts fifo_wr_en while fifo_full is 1.
- Other requesters' valid bits are ignored while LOCKED. Producers keep data and last stable while valid is high and ready is low.
- A beat with last and valid while fifo_full is 1 stays pending; the FSM remains in LOCKED.

## Timing
- Reset values:
  - FSM = IDLE, rr_ptr = 0, grant_valid = 0, grant_id = 0.
  - req_ready = 0, fifo_wr_en = 0, fifo_wr_data = 0.
- An asserted reset mid-packet returns the block to IDLE immediately. Any partially written packet remains in the queue; the block does not clean it up.
- Arbitration latency: the grant is visible one cycle after req_valid is seen in IDLE. The first beat can be accepted in that cycle.
- Each packet costs one idle arbitration cycle. Back-to-back single-beat packets therefore reach at most 1 write per 2 cycles.
- fifo_wr_en and req_ready are combinational from registered state, req_valid and fifo_full. There is no cycle of latency from fifo_full to the write stop.
- grant_valid = (state == LOCKED).

## Configuration
- Macro: ASYNC_QUEUE_WR_ARB_STATS_EN.
- **Defined:** the block adds per-requester 16-bit accepted-packet counters. Each counter increments when its requester's last beat is accepted and saturates at 16'hFFFF. Counters reset to 0. Extra ports:
  - stat_sel  in  ID_WIDTH  counter select.
  - stat_cnt  out  16  combinational read of the selected counter.
- **Undefined:** these ports and counters do not exist, and the behaviour of the rest of the block is unchanged.

## Structure
- Package async_queue_wr_arb_pkg holds:
  - the state typedef (IDLE, LOCKED);
  - STAT_WIDTH = 16.
- Sub-module async_queue_rr_pick: a purely combinational round-robin picker.
  - Inputs: req vector, pointer.
  - Outputs: found, index.
  - Instantiated once in IDLE arbitration.
- The top level contains the FSM, rr_ptr, the grant register, muxing and the optional counters.

## Test plan
- **Reset:** assert wr_rst_n = 0 mid-packet while LOCKED with g = 2 → next edge shows grant_valid = 0, req_ready = 0, fifo_wr_en = 0, rr_ptr = 0.
- **Fairness:** all 4 requesters hold single-beat packets continuously → grants cycle 0,1,2,3,0 and fifo_wr_en pulses every 2nd cycle.
- **Packet lock:** requester 1 sends 3 beats (last on the third) while requester 0 is also valid → three consecutive writes from requester 1 with no interleaving, then grant goes to 2 or the next valid requester (2,3,0 order).
- **Backpressure:** fifo_full = 1 for 5 cycles mid-packet → fifo_wr_en = 0 and req_ready = 0 throughout, grant_id unchanged, and the resumed beat equals the held data.
- **Wrap:** with NUM_REQ = 3, only requester 2 sends; then requesters 0 and 2 are both valid → requester 0 is granted next.
- **Stats** (with ASYNC_QUEUE_WR_ARB_STATS_EN): requester 3 completes 70000 packets → stat_sel = 3 reads 16'hFFFF; other counters read their exact counts.
